// File: rtl/outintf_pkg.sv
// rtl/outintf_pkg.sv - shared outFIFO interface constants and load FSM state encoding
package outintf_pkg;

  localparam int KB           = 14;
  localparam int HDDW         = 32;
  localparam int ADDRESSWIDTH = 5;
  localparam int UNLOADCOUNT  = 17;
  localparam int MAXOUTCYCLES = 223;
  localparam int SRCADDRWIDTH = 5;
  localparam int SRCBASE      = 0;
  localparam int GUARDCYCLES  = 2;

  localparam int ROWW    = KB * HDDW;
  localparam int ROWCNTW = $clog2(UNLOADCOUNT);
  localparam int GUARDW  = (GUARDCYCLES > 1) ? $clog2(GUARDCYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_EMPTY = 3'd1,
    LOAD       = 3'd2,
    DRAIN      = 3'd3,
    START      = 3'd4,
    GUARD      = 3'd5
  } load_state_t;

endpackage

// File: rtl/outfifo_load_fsm.sv
// rtl/outfifo_load_fsm.sv - copies decoder HD rows into outFIFO, then starts its read and acks the decoder
// Optional frame counter enabled by OUTLOAD_FRAMECNT_EN.
module outfifo_load_fsm
  import outintf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    siso_ready,
  output logic                    siso_ack,
  output logic                    src_rd_en,
  output logic [SRCADDRWIDTH-1:0] src_addr,
  input  logic [ROWW-1:0]         src_rd_data,
  input  logic                    fifo_empty,
  output logic [ADDRESSWIDTH-1:0] WA,
  output logic                    wr_en,
  output logic [ROWW-1:0]         WRDIN_kb,
  output logic                    rd_en,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  load_state_t             state_q, state_d;
  logic [ROWCNTW-1:0]      row_q, row_d;
  logic [GUARDW-1:0]       guard_q, guard_d;
  logic                    src_rd_en_d, wr_en_d, rd_en_d, ack_d;
  logic [SRCADDRWIDTH-1:0] src_addr_d;
  logic [ADDRESSWIDTH-1:0] wa_d;

  // Source data arrives the cycle wr_en is high, so it goes straight through.
  assign WRDIN_kb = src_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      guard_q   <= '0;
      src_rd_en <= 1'b0;
      src_addr  <= SRCADDRWIDTH'(SRCBASE);
      WA        <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      siso_ack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      guard_q   <= guard_d;
      src_rd_en <= src_rd_en_d;
      src_addr  <= src_addr_d;
      WA        <= wa_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      siso_ack  <= ack_d;
      busy      <= (state_d != IDLE);
    end
  end

  // Outputs are registered from the next-state decision, so each state's cycle shows its own strobes.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    guard_d     = guard_q;
    src_rd_en_d = 1'b0;
    src_addr_d  = src_addr;
    wa_d        = WA;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (siso_ready) begin
          if (fifo_empty) begin
            state_d     = LOAD;
            row_d       = '0;
            src_rd_en_d = 1'b1;
            src_addr_d  = SRCADDRWIDTH'(SRCBASE);
          end else begin
            state_d = WAIT_EMPTY;
          end
        end
      end
      WAIT_EMPTY: begin
        if (fifo_empty) begin
          state_d     = LOAD;
          row_d       = '0;
          src_rd_en_d = 1'b1;
          src_addr_d  = SRCADDRWIDTH'(SRCBASE);
        end
      end
      LOAD: begin
        wr_en_d = 1'b1;
        wa_d    = ADDRESSWIDTH'(row_q);
        if (row_q == ROWCNTW'(UNLOADCOUNT - 1)) begin
          state_d = DRAIN;
        end else begin
          row_d       = row_q + 1'b1;
          src_rd_en_d = 1'b1;
          src_addr_d  = SRCADDRWIDTH'(SRCBASE) + SRCADDRWIDTH'(row_d);
        end
      end
      DRAIN: begin
        state_d = START;
        rd_en_d = 1'b1;
        ack_d   = 1'b1;
      end
      START: begin
        state_d = GUARD;
        guard_d = '0;
      end
      GUARD: begin
        // outFIFO's empty flag lags the start pulse; ignore it until it settles.
        if (guard_q == GUARDW'(GUARDCYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef OUTLOAD_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (state_q == DRAIN) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_outfifo_load_fsm.sv
// tb/tb_outfifo_load_fsm.sv - directed self-checking bench for outfifo_load_fsm
module tb_outfifo_load_fsm;
  import outintf_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    siso_ready = 1'b0;
  logic                    siso_ack;
  logic                    src_rd_en;
  logic [SRCADDRWIDTH-1:0] src_addr;
  logic [ROWW-1:0]         src_rd_data = '0;
  logic                    fifo_empty = 1'b0;
  logic [ADDRESSWIDTH-1:0] WA;
  logic                    wr_en;
  logic [ROWW-1:0]         WRDIN_kb;
  logic                    rd_en;
  logic                    busy;
  logic [15:0]             frame_cnt;

  int total = 0;
  int bad   = 0;

  outfifo_load_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .siso_ready  (siso_ready),
    .siso_ack    (siso_ack),
    .src_rd_en   (src_rd_en),
    .src_addr    (src_addr),
    .src_rd_data (src_rd_data),
    .fifo_empty  (fifo_empty),
    .WA          (WA),
    .wr_en       (wr_en),
    .WRDIN_kb    (WRDIN_kb),
    .rd_en       (rd_en),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ROWW-1:0] row_pat(input int r);
    logic [ROWW-1:0] v;
    v = '0;
    for (int w = 0; w < KB; w++) v[w*HDDW +: HDDW] = 32'hA5A5_0000 + r;
    return v;
  endfunction

  // Decoder HD memory: one-cycle read latency.
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= row_pat(int'(src_addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects siso_ready=1 and fifo_empty=1 already driven in the current cycle (t0).
  task automatic check_frame(input logic drop_ready, input int drop_empty_at);
    logic exp_src, exp_wr, exp_rd, exp_busy;
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_src  = (k >= 1 && k <= 17);
      exp_wr   = (k >= 2 && k <= 18);
      exp_rd   = (k == 19);
      exp_busy = (k <= 21);
      total++;
      if (src_rd_en !== exp_src) begin bad++; $display("FAIL src_rd_en k=%0d got=%b exp=%b", k, src_rd_en, exp_src); end
      if (exp_src) begin
        total++;
        if (src_addr !== SRCADDRWIDTH'(k - 1)) begin bad++; $display("FAIL src_addr k=%0d got=%0d exp=%0d", k, src_addr, k - 1); end
      end
      total++;
      if (wr_en !== exp_wr) begin bad++; $display("FAIL wr_en k=%0d got=%b exp=%b", k, wr_en, exp_wr); end
      if (exp_wr) begin
        total++;
        if (WA !== ADDRESSWIDTH'(k - 2)) begin bad++; $display("FAIL WA k=%0d got=%0d exp=%0d", k, WA, k - 2); end
        total++;
        if (WRDIN_kb !== row_pat(k - 2)) begin bad++; $display("FAIL WRDIN_kb k=%0d got=%h exp=%h", k, WRDIN_kb, row_pat(k - 2)); end
      end
      total++;
      if (rd_en !== exp_rd) begin bad++; $display("FAIL rd_en k=%0d got=%b exp=%b", k, rd_en, exp_rd); end
      total++;
      if (siso_ack !== exp_rd) begin bad++; $display("FAIL siso_ack k=%0d got=%b exp=%b", k, siso_ack, exp_rd); end
      total++;
      if (busy !== exp_busy) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      if (k == drop_empty_at) fifo_empty = 1'b0;
      if (k == 19 && drop_ready) siso_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; siso_ready = 1'b0; fifo_empty = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (siso_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", siso_ack); end
    total++; if (src_rd_en !== 1'b0) begin bad++; $display("FAIL reset_src_rd_en got=%b exp=0", src_rd_en); end
    total++; if (src_addr !== SRCADDRWIDTH'(SRCBASE)) begin bad++; $display("FAIL reset_src_addr got=%0d exp=%0d", src_addr, SRCBASE); end
    total++; if (WA !== '0) begin bad++; $display("FAIL reset_WA got=%0d exp=0", WA); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_basic_load();
    fifo_empty = 1'b1;
    siso_ready = 1'b1;
    check_frame(1'b1, 0);
  endtask

  task automatic test_wait_empty();
    fifo_empty = 1'b0;
    siso_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      total++; if (src_rd_en !== 1'b0) begin bad++; $display("FAIL wait_src_rd_en c=%0d got=%b exp=0", c, src_rd_en); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL wait_wr_en c=%0d got=%b exp=0", c, wr_en); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy c=%0d got=%b exp=1", c, busy); end
    end
    fifo_empty = 1'b1;
    // fifo_empty drops again mid-load; the load must still complete.
    check_frame(1'b1, 5);
    fifo_empty = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n_rd = 0, first_rd = 0, second_rd = 0, second_load = 0;
    logic prev_en = 1'b0;
    fifo_empty = 1'b1;
    siso_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (rd_en) begin
        n_rd++;
        if (n_rd == 1) first_rd = c;
        if (n_rd == 2) begin second_rd = c; siso_ready = 1'b0; end
      end
      if (first_rd > 0 && second_load == 0 && src_rd_en && !prev_en) second_load = c;
      prev_en = src_rd_en;
    end
    total++; if (n_rd !== 2) begin bad++; $display("FAIL b2b_rd_count got=%0d exp=2", n_rd); end
    total++; if (first_rd !== 19) begin bad++; $display("FAIL b2b_first_rd got=%0d exp=19", first_rd); end
    total++; if (second_load !== 23) begin bad++; $display("FAIL b2b_second_load got=%0d exp=23", second_load); end
    total++; if (second_rd !== 41) begin bad++; $display("FAIL b2b_second_rd got=%0d exp=41", second_rd); end
  endtask

  task automatic test_reset_mid_load();
    int n_pulse = 0;
    fifo_empty = 1'b1;
    siso_ready = 1'b1;
    repeat (9) tick();
    total++; if (src_addr !== SRCADDRWIDTH'(8)) begin bad++; $display("FAIL mid_addr got=%0d exp=8", src_addr); end
    rst = 1'b1;
    siso_ready = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (src_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_src_rd_en got=%b exp=0", src_rd_en); end
    total++; if (src_addr !== SRCADDRWIDTH'(SRCBASE)) begin bad++; $display("FAIL mid_rst_src_addr got=%0d exp=0", src_addr); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en got=%b exp=0", wr_en); end
    total++; if (WA !== '0) begin bad++; $display("FAIL mid_rst_WA got=%0d exp=0", WA); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    total++; if (rd_en !== 1'b0 || siso_ack !== 1'b0) begin bad++; $display("FAIL mid_rst_pulses got=%b%b exp=00", rd_en, siso_ack); end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rd_en || siso_ack || busy) n_pulse++;
    end
    total++; if (n_pulse !== 0) begin bad++; $display("FAIL mid_rst_quiet got=%0d exp=0", n_pulse); end
    siso_ready = 1'b1;
    check_frame(1'b1, 0);
  endtask

  task automatic test_frame_count();
    logic [15:0] exp_cnt;
`ifdef OUTLOAD_FRAMECNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fifo_empty = 1'b1;
    for (int f = 0; f < 3; f++) begin
      siso_ready = 1'b1;
      check_frame(1'b1, 0);
    end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_wait_empty();
    test_back_to_back();
    test_reset_mid_load();
    test_frame_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
